// File: rtl/pixel_loader_pkg.sv
// Shared types and default sizes for the pixel vector loader.
`timescale 1ns/1ps
package pixel_loader_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_DEPTH = 24;
    localparam int DEF_LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        DONE
    } state_t;

    typedef logic [DEF_LANES*DEF_WIDTH-1:0] vec_t;

endpackage

// File: rtl/pixel_vector_loader_packer.sv
// Lane register file: one pixel word plus mask bit per lane.
`timescale 1ns/1ps
module lane_packer
    import pixel_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   we_i,
    input  logic [LW-1:0]          lane_i,
    input  logic                   hit_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [LANES*WIDTH-1:0] data_o,
    output logic [LANES-1:0]       mask_o
);

    logic [LANES*WIDTH-1:0] data_q;
    logic [LANES-1:0]       mask_q;

    // Out-of-range fetches still occupy their lane, as a zero with mask 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            mask_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
            mask_q <= '0;
        end else if (we_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_i == LW'(i)) begin
                    data_q[i*WIDTH +: WIDTH] <= hit_i ? din_i : '0;
                    mask_q[i]                <= hit_i;
                end
            end
        end
    end

    assign data_o = data_q;
    assign mask_o = mask_q;

endmodule

// File: rtl/pixel_vector_loader.sv
// Streams pixels from a combinational-read memory and packs them into vectors.
`timescale 1ns/1ps
module pixel_vector_loader
    import pixel_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LANES = DEF_LANES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       base_addr,
    input  logic [WIDTH-1:0]       count,
    output logic [WIDTH-1:0]       mem_addr,
    input  logic [WIDTH-1:0]       mem_rd,
    output logic [LANES*WIDTH-1:0] vec_data,
    output logic [LANES-1:0]       vec_mask,
    output logic                   vec_valid,
    input  logic                   vec_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]    lane_q, lane_d;

    logic [WIDTH-1:0] fetch_addr;
    logic             hit;
    logic             last_lane;
    logic             last_pix;
    logic             clr;
    logic             we;

    assign fetch_addr = base_q + idx_q;
    assign hit        = fetch_addr < WIDTH'(DEPTH);
    assign last_lane  = lane_q == LW'(LANES - 1);
    assign last_pix   = idx_q == cnt_q - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        clr     = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    cnt_d   = count;
                    idx_d   = '0;
                    lane_d  = '0;
                    clr     = 1'b1;
                    state_d = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                we     = 1'b1;
                addr_d = fetch_addr;
                idx_d  = idx_q + 1'b1;
                lane_d = lane_q + 1'b1;
                if (last_lane || last_pix) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (vec_ready) begin
                    if (idx_q == cnt_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        lane_d  = '0;
                        clr     = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address is live only while fetching; otherwise the last one is held.
    always_comb begin
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        vec_valid = state_q == EMIT;
        mem_addr  = (state_q == FETCH) ? fetch_addr : addr_q;
    end

    lane_packer #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_packer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .we_i   (we),
        .lane_i (lane_q),
        .hit_i  (hit),
        .din_i  (mem_rd),
        .data_o (vec_data),
        .mask_o (vec_mask)
    );

endmodule

// File: tb/tb_pixel_vector_loader.sv
// Directed bench for pixel_vector_loader with a preloaded pixel memory.
`timescale 1ns/1ps
module tb_pixel_vector_loader;
    import pixel_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] base_addr = '0;
    logic [23:0] count = '0;
    logic [23:0] mem_addr;
    logic [23:0] mem_rd;
    vec_t        vec_data;
    logic [3:0]  vec_mask;
    logic        vec_valid;
    logic        vec_ready = 1'b0;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    vec_t       q_data[$];
    logic [3:0] q_mask[$];
    int         done_cnt = 0;
    int         busy_cnt = 0;
    int         valid_cnt = 0;

    logic [23:0] mem [0:31];

    pixel_vector_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .vec_data  (vec_data),
        .vec_mask  (vec_mask),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Out-of-range reads return junk so leakage into lanes is visible.
    always_comb begin
        mem_rd = (mem_addr < 24'd24) ? mem[mem_addr[4:0]] : 24'hBAD0BA;
    end

    always @(negedge clk) begin
        if (vec_valid && vec_ready) begin
            q_data.push_back(vec_data);
            q_mask.push_back(vec_mask);
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (vec_valid) valid_cnt++;
    end

    task automatic clear_log();
        q_data.delete();
        q_mask.delete();
        done_cnt = 0;
        busy_cnt = 0;
        valid_cnt = 0;
    endtask

    task automatic start_job(input logic [23:0] b, input logic [23:0] c);
        @(posedge clk); #1;
        base_addr = b;
        count = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = '1;
        count = '1;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({mem_addr, vec_mask, vec_valid, busy, done} !== '0) begin
            $display("FAIL reset_ctl: actual addr=%h mask=%h v=%b b=%b d=%b required all 0",
                     mem_addr, vec_mask, vec_valid, busy, done);
            bad++;
        end
        total++;
        if (vec_data !== '0) begin
            $display("FAIL reset_data: actual=%h required=0", vec_data);
            bad++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit seen;
        vec_ready = 1'b1;
        clear_log();
        start_job(24'd0, 24'd8);
        wait_done(40, seen);
        total++;
        if (seen !== 1'b1) begin
            $display("FAIL basic_done: actual=0 required=1");
            bad++;
        end
        total++;
        if (q_data.size() !== 2) begin
            $display("FAIL basic_nvec: actual=%0d required=2", q_data.size());
            bad++;
        end else begin
            total++;
            if (q_data[0] !== {24'h4, 24'h3, 24'h2, 24'h1} || q_mask[0] !== 4'hF) begin
                $display("FAIL basic_vec0: actual=%h/%h required=000004000003000002000001/f",
                         q_data[0], q_mask[0]);
                bad++;
            end
            total++;
            if (q_data[1] !== {24'h8, 24'h7, 24'h6, 24'h5} || q_mask[1] !== 4'hF) begin
                $display("FAIL basic_vec1: actual=%h/%h required=000008000007000006000005/f",
                         q_data[1], q_mask[1]);
                bad++;
            end
        end
        total++;
        if (done_cnt !== 1) begin
            $display("FAIL basic_done_cnt: actual=%0d required=1", done_cnt);
            bad++;
        end
        total++;
        if (busy_cnt !== 11) begin
            $display("FAIL basic_busy_cycles: actual=%0d required=11", busy_cnt);
            bad++;
        end
    endtask

    task automatic test_partial();
        bit seen;
        vec_ready = 1'b1;
        clear_log();
        start_job(24'd2, 24'd6);
        wait_done(40, seen);
        total++;
        if (seen !== 1'b1 || q_data.size() !== 2) begin
            $display("FAIL partial_nvec: actual done=%b n=%0d required done=1 n=2",
                     seen, q_data.size());
            bad++;
        end else begin
            total++;
            if (q_data[0] !== {24'h6, 24'h5, 24'h4, 24'h3} || q_mask[0] !== 4'hF) begin
                $display("FAIL partial_vec0: actual=%h/%h required=000006000005000004000003/f",
                         q_data[0], q_mask[0]);
                bad++;
            end
            total++;
            if (q_data[1] !== {24'h0, 24'h0, 24'h8, 24'h7} || q_mask[1] !== 4'h3) begin
                $display("FAIL partial_vec1: actual=%h/%h required=000000000000000008000007/3",
                         q_data[1], q_mask[1]);
                bad++;
            end
        end
    endtask

    task automatic test_out_of_range();
        bit seen;
        vec_ready = 1'b1;
        clear_log();
        start_job(24'd22, 24'd4);
        wait_done(40, seen);
        total++;
        if (seen !== 1'b1 || done_cnt !== 1) begin
            $display("FAIL oor_done: actual seen=%b cnt=%0d required 1/1", seen, done_cnt);
            bad++;
        end
        total++;
        if (q_data.size() !== 1) begin
            $display("FAIL oor_nvec: actual=%0d required=1", q_data.size());
            bad++;
        end else begin
            total++;
            if (q_data[0] !== {24'h0, 24'h0, 24'h18, 24'h17} || q_mask[0] !== 4'h3) begin
                $display("FAIL oor_vec: actual=%h/%h required=000000000000000018000017/3",
                         q_data[0], q_mask[0]);
                bad++;
            end
        end
        total++;
        if (mem_addr !== 24'd25) begin
            $display("FAIL oor_addr_hold: actual=%0d required=25", mem_addr);
            bad++;
        end
    endtask

    task automatic test_zero_count();
        bit seen;
        vec_ready = 1'b1;
        clear_log();
        start_job(24'd5, 24'd0);
        wait_done(2, seen);
        total++;
        if (seen !== 1'b1 || done_cnt !== 1) begin
            $display("FAIL zero_done: actual seen=%b cnt=%0d required 1/1", seen, done_cnt);
            bad++;
        end
        total++;
        if (valid_cnt !== 0) begin
            $display("FAIL zero_valid: actual=%0d required=0", valid_cnt);
            bad++;
        end
        total++;
        if (busy_cnt !== 1) begin
            $display("FAIL zero_busy: actual=%0d required=1", busy_cnt);
            bad++;
        end
    endtask

    task automatic test_stall();
        bit seen;
        bit got;
        vec_ready = 1'b0;
        clear_log();
        start_job(24'd0, 24'd8);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (vec_valid) got = 1'b1;
        end
        total++;
        if (got !== 1'b1) begin
            $display("FAIL stall_valid_timeout: actual=0 required=1");
            bad++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (vec_valid !== 1'b1 || vec_data !== {24'h4, 24'h3, 24'h2, 24'h1}
                || mem_addr !== 24'd3) begin
                $display("FAIL stall_hold%0d: actual v=%b d=%h a=%0d required v=1 d=000004000003000002000001 a=3",
                         i, vec_valid, vec_data, mem_addr);
                bad++;
            end
            @(posedge clk); #1;
            start = (i == 1);
            base_addr = 24'd10;
            count = 24'd1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        vec_ready = 1'b1;
        wait_done(40, seen);
        total++;
        if (seen !== 1'b1 || done_cnt !== 1 || q_data.size() !== 2) begin
            $display("FAIL stall_end: actual done=%b cnt=%0d n=%0d required 1/1/2",
                     seen, done_cnt, q_data.size());
            bad++;
        end else begin
            total++;
            if (q_data[0] !== {24'h4, 24'h3, 24'h2, 24'h1}
                || q_data[1] !== {24'h8, 24'h7, 24'h6, 24'h5}
                || q_mask[1] !== 4'hF) begin
                $display("FAIL stall_vecs: actual=%h,%h/%h required 000004000003000002000001,000008000007000006000005/f",
                         q_data[0], q_data[1], q_mask[1]);
                bad++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit got;
        int d0;
        vec_ready = 1'b1;
        clear_log();
        start_job(24'd0, 24'd8);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (vec_valid) got = 1'b1;
        end
        total++;
        if (got !== 1'b1) begin
            $display("FAIL rstmid_valid_timeout: actual=0 required=1");
            bad++;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if ({mem_addr, vec_mask, vec_valid, busy, done} !== '0 || vec_data !== '0) begin
            $display("FAIL rstmid_outputs: actual addr=%h d=%h m=%h v=%b b=%b required all 0",
                     mem_addr, vec_data, vec_mask, vec_valid, busy);
            bad++;
        end
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (done_cnt !== d0 || busy !== 1'b0 || mem_addr !== 24'd0) begin
            $display("FAIL rstmid_quiet: actual done=%0d busy=%b addr=%0d required done=%0d busy=0 addr=0",
                     done_cnt, busy, mem_addr, d0);
            bad++;
        end
        clear_log();
        start_job(24'd4, 24'd4);
        wait_done(40, seen);
        total++;
        if (seen !== 1'b1 || q_data.size() !== 1) begin
            $display("FAIL rstmid_rerun: actual done=%b n=%0d required 1/1", seen, q_data.size());
            bad++;
        end else begin
            total++;
            if (q_data[0] !== {24'h8, 24'h7, 24'h6, 24'h5} || q_mask[0] !== 4'hF) begin
                $display("FAIL rstmid_vec: actual=%h/%h required=000008000007000006000005/f",
                         q_data[0], q_mask[0]);
                bad++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 24'(i + 1);
        test_reset();
        test_basic();
        test_partial();
        test_out_of_range();
        test_zero_count();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_vector_loader.md
Name: pixel_vector_loader

Overview:
- Sequencer directly upstream of the colour/pixel data memory.
- Generates sequential read addresses into that combinational-read memory and captures each returned pixel word.
- Packs LANES pixels into one vector word and hands it downstream to the vector register/lane path over a valid/ready handshake.
- One software-visible job = one start pulse; the job streams `count` pixels beginning at `base_addr`.

Parameters:
- WIDTH, 24, pixel word width and address width (matches the data memory).
- DEPTH, 24, number of valid memory entries; addresses >= DEPTH are out of range.
- LANES, 4, pixels packed per output vector.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- base_addr  in  WIDTH  first pixel address; latched on accepted start.
- count  in  WIDTH  pixels to load; latched on accepted start.
- mem_addr  out  WIDTH  address to data memory; read data returns combinationally, same cycle.
- mem_rd  in  WIDTH  pixel word from data memory.
- vec_data  out  LANES*WIDTH  packed vector; lane i occupies bits [i*WIDTH +: WIDTH], lane 0 at LSB.
- vec_mask  out  LANES  per-lane valid bits.
- vec_valid  out  1  vec_data/vec_mask are valid.
- vec_ready  in  1  downstream accepts when vec_valid && vec_ready at a rising edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset (async): state=IDLE, mem_addr=0, vec_data=0, vec_mask=0, vec_valid=0, busy=0, done=0, internal idx/lane counters=0.
- States: IDLE, FETCH, EMIT, DONE.
- IDLE:
  - start=1 latches base_addr/count and clears idx, lane, vec_data and vec_mask.
  - count==0 goes to DONE; otherwise goes to FETCH.
- FETCH, each cycle:
  - mem_addr = base+idx, computed as a WIDTH-bit sum; overflow wraps modulo 2^WIDTH.
  - In range (address < DEPTH): lane[lane] <= mem_rd and mask[lane] <= 1.
  - Out of range: lane <= 0 and mask[lane] <= 0; the fetch still consumes one cycle and one count.
  - idx++ and lane++.
  - Go to EMIT when lane==LANES-1 or idx==count-1.
- EMIT:
  - vec_valid=1; vec_data and vec_mask are held stable while waiting.
  - On handshake, vec_valid drops the next cycle.
  - After handshake, if idx==count go to DONE; otherwise go to FETCH with lane=0 and vec_data/vec_mask cleared.
- Partial final vector: unfilled lanes are 0 with mask 0.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops together with the return to IDLE.
- Latency:
  - Start accepted at edge k; fetches occur at edges k+1..k+LANES; vec_valid is high after edge k+LANES.
  - With vec_ready tied high, steady-state throughput is one vector per LANES+1 cycles.
- start while busy is ignored, not queued. base_addr/count changes after acceptance have no effect.
- vec_ready while vec_valid=0 is ignored.
- In IDLE/EMIT/DONE, mem_addr holds its last value.
- rst mid-job aborts immediately to the reset values. No done pulse is emitted and no partial vector is presented.
- Max job: count up to 2^WIDTH-1; the idx comparator is WIDTH bits wide.

Decomposition:
- Package pixel_loader_pkg: state enum (IDLE, FETCH, EMIT, DONE), default WIDTH/DEPTH/LANES constants, and a typedef for the packed vector (logic [LANES*WIDTH-1:0]).
- One natural sub-module, lane_packer: holds the LANES x WIDTH registers and mask, with write-enable, lane index, clear, and data-in. The FSM and counters stay in the top.

Test Plan:
- Memory preloaded 0x000001..0x000018; base=0, count=8, vec_ready=1 -> two vectors: data {4,3,2,1} then {8,7,6,5} (hex, lane3..lane0), mask 4'hF each; done pulses once; busy high from the cycle after start until done.
- base=2, count=6 -> vector {6,5,4,3} mask F, then vector {0,0,8,7} mask 4'h3; exactly 2 handshakes.
- base=22, count=4 -> addresses 22,23,24,25; vector {0,0,0x18,0x17}, mask 4'h3; done asserted.
- count=0 with start -> no vec_valid; done pulses within 2 cycles; busy high for exactly 1 cycle.
- vec_ready held low for 5 cycles during EMIT -> vec_valid and vec_data remain stable and mem_addr does not advance; start pulsed mid-job is ignored; the next vector follows after ready rises.
- rst asserted asynchronously during FETCH of the second vector -> all outputs return to 0 immediately, no done pulse; a subsequent start runs a clean job with correct data.
